fetch_decode: RTL and testbench



---
 rtl/viola_pkg.sv | 38 +++
 rtl/fetch_decode_instr_decoder.sv | 80 ++++++++
 rtl/fetch_decode.sv | 135 +++++++++++++
 tb/tb_fetch_decode.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/viola_pkg.sv
// viola_pkg: op codes, RV32I encodings and front-end state shared by fetch_decode.
package viola_pkg;
  localparam logic [4:0] OP_LUI = 5'd0, OP_AUIPC = 5'd1, OP_JAL = 5'd2, OP_JALR = 5'd3;
  localparam logic [4:0] OP_BEQ = 5'd4, OP_BNE = 5'd5, OP_BLT = 5'd6, OP_BGE = 5'd7;
  localparam logic [4:0] OP_BLTU = 5'd8, OP_BGEU = 5'd9;
  localparam logic [4:0] OP_LB = 5'd10, OP_LH = 5'd11, OP_LW = 5'd12, OP_LBU = 5'd13, OP_LHU = 5'd14;
  localparam logic [4:0] OP_SB = 5'd15, OP_SH = 5'd16, OP_SW = 5'd17;
  localparam logic [4:0] OP_ADD = 5'd18, OP_SUB = 5'd19, OP_SLL = 5'd20, OP_SLT = 5'd21;
  localparam logic [4:0] OP_SLTU = 5'd22, OP_XOR = 5'd23, OP_SRL = 5'd24, OP_SRA = 5'd25;
  localparam logic [4:0] OP_OR = 5'd26, OP_AND = 5'd27, OP_NOP = 5'b11111;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
  localparam logic [2:0] F3_SLL = 3'd1, F3_SR = 3'd5;
  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_e;
  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        has_imm;
  } dec_t;
  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? OP_SUB : OP_ADD;
      3'd1:    return OP_SLL;
      3'd2:    return OP_SLT;
      3'd3:    return OP_SLTU;
      3'd4:    return OP_XOR;
      3'd5:    return alt ? OP_SRA : OP_SRL;
      3'd6:    return OP_OR;
      default: return OP_AND;
    endcase
  endfunction
endpackage

// File: rtl/fetch_decode_instr_decoder.sv
// instr_decoder: combinational RV32I word to compact queue format, flags illegal words and FENCE.
module instr_decoder
  import viola_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [4:0]  op_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic        has_imm_o,
  output logic        illegal_o,
  output logic        is_fence_o
);
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt;
  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign rd_f  = inst_i[11:7];
  assign rs1_f = inst_i[19:15];
  assign rs2_f = inst_i[24:20];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign shamt = {27'b0, inst_i[24:20]};
  always_comb begin
    op_o       = OP_NOP;
    rs1_o      = '0;
    rs2_o      = '0;
    rd_o       = '0;
    imm_o      = '0;
    has_imm_o  = 1'b1;
    illegal_o  = 1'b0;
    is_fence_o = 1'b0;
    case (opc)
      OPC_LUI:    begin op_o = OP_LUI; rd_o = rd_f; imm_o = imm_u; end
      OPC_AUIPC:  begin op_o = OP_AUIPC; rd_o = rd_f; imm_o = imm_u; end
      OPC_JAL:    begin op_o = OP_JAL; rd_o = rd_f; imm_o = imm_j; end
      OPC_JALR:   begin op_o = OP_JALR; rd_o = rd_f; rs1_o = rs1_f; imm_o = imm_i; illegal_o = f3 != 3'd0; end
      OPC_BRANCH: begin
        op_o = f3[2] ? OP_BLT + {3'b0, f3[1:0]} : OP_BEQ + {4'b0, f3[0]};
        rs1_o = rs1_f; rs2_o = rs2_f; imm_o = imm_b; illegal_o = f3[2:1] == 2'b01;
      end
      OPC_LOAD:   begin
        op_o = f3[2] ? OP_LBU + {4'b0, f3[0]} : OP_LB + {3'b0, f3[1:0]};
        rd_o = rd_f; rs1_o = rs1_f; imm_o = imm_i; illegal_o = f3 == 3'd3 || f3[2:1] == 2'b11;
      end
      OPC_STORE:  begin
        op_o = OP_SB + {3'b0, f3[1:0]};
        rs1_o = rs1_f; rs2_o = rs2_f; imm_o = imm_s; illegal_o = f3 > 3'd2;
      end
      OPC_OPIMM:  begin
        op_o = alu_op(f3, f3 == F3_SR && inst_i[30]);
        rd_o = rd_f; rs1_o = rs1_f;
        imm_o = f3[1:0] == 2'b01 ? shamt : imm_i;
        illegal_o = f3 == F3_SLL ? f7 != F7_BASE : f3 == F3_SR ? f7 != F7_BASE && f7 != F7_ALT : 1'b0;
      end
      OPC_OP:     begin
        op_o = alu_op(f3, f7 == F7_ALT);
        rd_o = rd_f; rs1_o = rs1_f; rs2_o = rs2_f; has_imm_o = 1'b0;
        illegal_o = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'd0 || f3 == F3_SR)));
      end
      OPC_FENCE:  begin is_fence_o = f3 == 3'd0; illegal_o = f3 != 3'd0; end
      default:    illegal_o = 1'b1;
    endcase
    if (illegal_o || is_fence_o) begin
      op_o      = OP_NOP;
      rs1_o     = '0;
      rs2_o     = '0;
      rd_o      = '0;
      imm_o     = '0;
      has_imm_o = 1'b0;
    end
  end
endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: fetches one RV32I word at a time and emits it decoded to the instruction queue,
// holding it while the queue is full and honouring branch redirects.
module fetch_decode
  import viola_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [4:0]  op,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        has_imm,
  output logic [31:0] pc_out,
  output logic        illegal
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, mem_addr_q, mem_addr_d, pc_out_q, pc_out_d;
  logic        mem_req_q, mem_req_d, discard_q, discard_d, illegal_q, illegal_d;
  dec_t        out_q, out_d, hold_q, hold_d, dec;
  logic        dec_illegal, dec_fence;
  instr_decoder u_dec (
    .inst_i     (mem_rdata),
    .op_o       (dec.op),
    .rs1_o      (dec.rs1),
    .rs2_o      (dec.rs2),
    .rd_o       (dec.rd),
    .imm_o      (dec.imm),
    .has_imm_o  (dec.has_imm),
    .illegal_o  (dec_illegal),
    .is_fence_o (dec_fence)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      discard_q  <= 1'b0;
      out_q      <= '{op: OP_NOP, default: '0};
      hold_q     <= '{op: OP_NOP, default: '0};
      pc_out_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      discard_q  <= discard_d;
      out_q      <= out_d;
      hold_q     <= hold_d;
      pc_out_q   <= pc_out_d;
      illegal_q  <= illegal_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = !redirect_valid && !iq_full ? WAIT : FETCH;
      WAIT:    state_d = !mem_ready ? WAIT
                       : discard_q || redirect_valid || dec_illegal || dec_fence || !iq_full ? FETCH : HOLD;
      HOLD:    state_d = redirect_valid || !iq_full ? FETCH : HOLD;
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    out_d      = out_q;
    out_d.op   = OP_NOP;
    hold_d     = hold_q;
    pc_out_d   = pc_out_q;
    illegal_d  = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect_valid) pc_d = redirect_pc;
        else if (!iq_full) begin
          mem_req_d  = 1'b1;
          mem_addr_d = {pc_q[31:2], 2'b00};
        end
      end
      WAIT: begin
        if (!mem_ready) begin
          if (redirect_valid) begin
            pc_d      = redirect_pc;
            discard_d = 1'b1;
          end
        end else begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          // A stale or redirected word is dropped; pc already points at the new target unless redirected now.
          if (discard_q || redirect_valid) pc_d = redirect_valid ? redirect_pc : pc_q;
          else if (dec_illegal || dec_fence) begin
            illegal_d = dec_illegal;
            pc_d      = pc_q + 32'd4;
          end else if (!iq_full) begin
            out_d    = dec;
            pc_out_d = pc_q;
            pc_d     = pc_q + 32'd4;
          end else hold_d = dec;
        end
      end
      HOLD: begin
        if (redirect_valid) pc_d = redirect_pc;
        else if (!iq_full) begin
          out_d    = hold_q;
          pc_out_d = pc_q;
          pc_d     = pc_q + 32'd4;
        end
      end
      default: ;
    endcase
  end
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign op       = out_q.op;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign rd       = out_q.rd;
  assign imm      = out_q.imm;
  assign has_imm  = out_q.has_imm;
  assign pc_out   = pc_out_q;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vectors with hand-computed expectations for fetch_decode.
module tb_fetch_decode;
  logic        clk = 1'b0;
  logic        rst, mem_req, mem_ready, iq_full, redirect_valid, has_imm, illegal;
  logic [31:0] mem_addr, mem_rdata, redirect_pc, imm, pc_out;
  logic [4:0]  op, rs1, rs2, rd;
  int checks = 0;
  int errors = 0;
  fetch_decode #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .iq_full(iq_full), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .has_imm(has_imm), .pc_out(pc_out), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_emit(input string tag, input logic [4:0] e_op, input logic [4:0] e_rd,
                            input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                            input logic [31:0] e_imm, input logic e_hi, input logic [31:0] e_pc);
    check({tag, ".op"}, {27'b0, op}, {27'b0, e_op});
    check({tag, ".rd"}, {27'b0, rd}, {27'b0, e_rd});
    check({tag, ".rs1"}, {27'b0, rs1}, {27'b0, e_rs1});
    check({tag, ".rs2"}, {27'b0, rs2}, {27'b0, e_rs2});
    check({tag, ".imm"}, imm, e_imm);
    check({tag, ".has_imm"}, {31'b0, has_imm}, {31'b0, e_hi});
    check({tag, ".pc_out"}, pc_out, e_pc);
  endtask
  task automatic respond(input logic [31:0] w);
    mem_ready = 1'b1;
    mem_rdata = w;
    tick();
    mem_ready = 1'b0;
  endtask
  logic [31:0] s_word [4] = '{32'h402081B3, 32'hFE208EE3, 32'h4032D293, 32'h123453B7};
  logic [4:0]  s_op   [4] = '{5'd19, 5'd4, 5'd25, 5'd0};
  logic [4:0]  s_rd   [4] = '{5'd3, 5'd0, 5'd5, 5'd7};
  logic [4:0]  s_rs1  [4] = '{5'd1, 5'd1, 5'd5, 5'd0};
  logic [4:0]  s_rs2  [4] = '{5'd2, 5'd2, 5'd0, 5'd0};
  logic [31:0] s_imm  [4] = '{32'h0, 32'hFFFFFFFC, 32'h3, 32'h12345000};
  logic        s_hi   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  initial begin
    rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0; iq_full = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("rst.op", {27'b0, op}, 32'd31);
    check("rst.mem_req", {31'b0, mem_req}, 32'd0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.illegal", {31'b0, illegal}, 32'd0);
    check("rst.pc_out", pc_out, 32'h0);
    check("rst.has_imm", {31'b0, has_imm}, 32'd0);
    rst = 1'b1;
    tick();
    check("t1.mem_req", {31'b0, mem_req}, 32'd1);
    check("t1.mem_addr", mem_addr, 32'h100);
    respond(32'h00500093);
    check_emit("t1", 5'd18, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h100);
    check("t1.req_drop", {31'b0, mem_req}, 32'd0);
    tick();
    check("t1.bubble", {27'b0, op}, 32'd31);
    check("t1.next_addr", mem_addr, 32'h104);
    for (int i = 0; i < 4; i++) begin
      respond(s_word[i]);
      check_emit($sformatf("t2[%0d]", i), s_op[i], s_rd[i], s_rs1[i], s_rs2[i], s_imm[i], s_hi[i],
                 32'h104 + 32'(4 * i));
      tick();
      check($sformatf("t2[%0d].bubble", i), {27'b0, op}, 32'd31);
      check($sformatf("t2[%0d].addr", i), mem_addr, 32'h108 + 32'(4 * i));
    end
    iq_full = 1'b1;
    respond(32'h00A00113);
    check("t3.full0", {27'b0, op}, 32'd31);
    for (int i = 1; i < 5; i++) begin
      tick();
      check($sformatf("t3.full%0d", i), {27'b0, op}, 32'd31);
    end
    iq_full = 1'b0;
    tick();
    check_emit("t3", 5'd18, 5'd2, 5'd0, 5'd0, 32'd10, 1'b1, 32'h114);
    tick();
    check("t3.no_dup", {27'b0, op}, 32'd31);
    check("t3.next_addr", mem_addr, 32'h118);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t4.req_held", {31'b0, mem_req}, 32'd1);
    respond(32'h00500093);
    check("t4.dropped", {27'b0, op}, 32'd31);
    tick();
    check("t4.dropped2", {27'b0, op}, 32'd31);
    check("t4.new_addr", mem_addr, 32'h200);
    respond(32'hFFFFFFFF);
    check("t5.illegal", {31'b0, illegal}, 32'd1);
    check("t5.op", {27'b0, op}, 32'd31);
    tick();
    check("t5.illegal_clr", {31'b0, illegal}, 32'd0);
    check("t5.next_addr", mem_addr, 32'h204);
    respond(32'h0000000F);
    check("fence.op", {27'b0, op}, 32'd31);
    check("fence.illegal", {31'b0, illegal}, 32'd0);
    tick();
    check("fence.next_addr", mem_addr, 32'h208);
    rst = 1'b0;
    tick();
    check("t6.mem_req", {31'b0, mem_req}, 32'd0);
    check("t6.op", {27'b0, op}, 32'd31);
    rst = 1'b1; iq_full = 1'b1;
    mem_rdata = 32'h00500093; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t6.ignore_ready", {27'b0, op}, 32'd31);
    check("t6.no_req_full", {31'b0, mem_req}, 32'd0);
    iq_full = 1'b0;
    tick();
    check("t6.addr", mem_addr, 32'h100);
    respond(32'h00500093);
    check("wrap.emit_pc", pc_out, 32'h100);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap.redir_no_req", {31'b0, mem_req}, 32'd0);
    tick();
    check("wrap.addr", mem_addr, 32'hFFFFFFFC);
    respond(32'h00500093);
    check("wrap.pc_out", pc_out, 32'hFFFFFFFC);
    tick();
    check("wrap.next_addr", mem_addr, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
